wynik_bufor: RTL
================

// Module: wynik_bufor
// PURPOSE
//  Registered output stage of the synchronous arithmetic unit, directly downstream of
//  the combinational shift block (przesuniecie) and its siblings.
//  Captures result/error words through a valid/ready handshake into a 2-entry FIFO.
//  Presents each word with derived sign-magnitude status flags.
//  Keeps a saturating count of accepted error words.
// PARAMETERS
//  BITS   32  data width; sign-magnitude word, MSB = sign, magnitude in [BITS-2:0]
//  CNT_W  8   width of the error counter
// PORTS
//  i_clk        in   1       clock, all state updates on rising edge
//  i_rst_n      in   1       asynchronous, active-low reset
//  i_clear      in   1       synchronous clear of o_err_cnt only
//  i_valid      in   1       upstream word present on i_result/i_error
//  i_result     in   BITS    result from the arithmetic block (o_result)
//  i_error      in   1       error from the arithmetic block (o_error)
//  o_ready      out  1       stage can accept a word this cycle
//  o_valid      out  1       head entry valid
//  i_ready      in   1       downstream consumes head entry this cycle
//  o_result     out  BITS    head entry data
//  o_error      out  1       head entry error
//  o_zero       out  1       head entry is +0 or -0 (magnitude == 0)
//  o_neg        out  1       head entry is negative, nonzero
//  o_err_cnt    out  CNT_W   number of accepted error words, saturating
// BEHAVIOUR
//  Reset (i_rst_n=0, any time, async)
//   - FIFO emptied; o_valid=0, o_ready=1.
//   - o_result=0, o_error=0, o_zero=0, o_neg=0, o_err_cnt=0.
//   - Reset mid-transfer discards both entries; no partial state survives.
//  Handshake
//   - push = i_valid & o_ready; pop = o_valid & i_ready.
//   - o_ready = (count < 2); combinational from registered count only.
//   - Upstream holds i_result/i_error stable while i_valid=1 and o_ready=0.
//   - Latency: a word pushed at edge N is visible on outputs after edge N (o_valid=1 from N).
//   - Order preserved (FIFO); head outputs are registers, no input->output comb path.
//  Count transitions (count in {0,1,2})
//   - 0: push -> 1; pop impossible.
//   - 1: push&pop -> 1 (new word becomes head); push only -> 2; pop only -> 0.
//   - 2: o_ready=0, no push; pop -> 1, second entry moves to head.
//  Flags (computed at push, stored per entry)
//   - i_error=1: stored result forced to 0, zero=0, neg=0, error=1; error dominates.
//   - else zero = (i_result[BITS-2:0]==0), independent of sign bit.
//   - else neg = i_result[BITS-1] & ~zero; -0 ({1,0..0}) gives zero=1, neg=0.
//  Error counter
//   - +1 on each push with i_error=1; holds at 2**CNT_W-1 (no wrap).
//   - i_clear=1 zeroes it; if push with error in same cycle, clear wins (result 0).
//  When o_valid=0, o_result/o_error/o_zero/o_neg are 0.
// TESTING
//  1 reset, push {0,7FFFFFFF} err=0, i_ready=1 -> next cycle o_valid=1, o_result=7FFFFFFF, zero=0, neg=0
//  2 push 80000000 then 00000000 -> both give o_zero=1, o_neg=0; push 80000005 -> o_neg=1
//  3 i_ready=0, push 3 words A,B,C -> o_ready=0 after B, C held; release -> A,B,C in order, none lost
//  4 count=1, push and pop same cycle for 10 cycles -> count stays 1, o_ready stays 1, data in order
//  5 CNT_W=2, push 5 error words -> o_err_cnt 1,2,3,3,3, o_result=0; then i_clear -> 0
//  6 i_rst_n=0 async with count=2 -> o_valid=0, o_ready=1, o_err_cnt=0 before next clock edge

Source files
------------

// File: rtl/wynik_bufor.sv
// wynik_bufor: two-entry output FIFO for arithmetic results with sign-magnitude flags and error count
module wynik_bufor #(
  parameter int BITS  = 32,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [BITS-1:0]  i_result,
  input  logic             i_error,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [BITS-1:0]  o_result,
  output logic             o_error,
  output logic             o_zero,
  output logic             o_neg,
  output logic [CNT_W-1:0] o_err_cnt
);
  // entry layout: {result, error, zero, neg}
  logic [1:0]      r_cnt;
  logic [BITS+2:0] r_head, r_tail, w_in;
  logic            w_push, w_pop, w_zero;
  assign o_ready = r_cnt != 2'd2;
  assign o_valid = r_cnt != 2'd0;
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;
  assign w_zero  = i_result[BITS-2:0] == '0;
  assign w_in    = i_error ? {{BITS{1'b0}}, 3'b100}
                           : {i_result, 1'b0, w_zero, i_result[BITS-1] & ~w_zero};
  assign o_result = r_head[BITS+2:3];
  assign o_error  = r_head[2];
  assign o_zero   = r_head[1];
  assign o_neg    = r_head[0];
  // FIFO storage; a vacated head is zeroed so idle outputs read 0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= 2'd0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      if (w_pop)
        r_head <= (r_cnt == 2'd2) ? r_tail : (w_push ? w_in : '0);
      else if (w_push && r_cnt == 2'd0)
        r_head <= w_in;
      if (w_push && !w_pop && r_cnt == 2'd1)
        r_tail <= w_in;
      else if (w_pop && r_cnt == 2'd2)
        r_tail <= '0;
    end
  end
  // saturating count of accepted error words; clear takes priority
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_err_cnt <= '0;
    else if (i_clear)
      o_err_cnt <= '0;
    else if (w_push && i_error && o_err_cnt != {CNT_W{1'b1}})
      o_err_cnt <= o_err_cnt + 1'b1;
  end
endmodule
